// File: rtl/nvm_core_sequencer.sv
// rtl/nvm_core_sequencer.sv - Wishbone master sequencing one inference picture through the NVM core.
// Synapse-row reads, one spike-out read per timestep, then a picture-done write.
module nvm_core_sequencer #(
  parameter int          NUM_ROWS    = 16,
  parameter int          NUM_STEPS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic        spike_valid,
  output logic [31:0] spike_data,
  output logic [7:0]  spike_step
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SYN_RD  = 3'd1;
  localparam logic [2:0] SPK_RD  = 3'd2;
  localparam logic [2:0] DONE_WR = 3'd3;
  localparam logic [2:0] GAP     = 3'd4;

  localparam logic [11:0] LAST_ROW  = 12'(NUM_ROWS - 1);
  localparam logic [7:0]  LAST_STEP = 8'(NUM_STEPS - 1);
  localparam logic [7:0]  TMO_LAST  = 8'(ACK_TIMEOUT - 1);

  logic [2:0]  state;
  logic [2:0]  pend;
  logic [11:0] row;
  logic [7:0]  step;
  logic [7:0]  tmo;
  logic [15:0] nxt_off;

  // Row offsets are concatenated so the row index can never spill into the region bits.
  always_comb begin
    nxt_off = 16'h0000;
    case (pend)
      SYN_RD:  nxt_off = {4'h0, row[9:0], 2'b00};
      SPK_RD:  nxt_off = 16'h1000;
      DONE_WR: nxt_off = 16'h2000;
      default: nxt_off = 16'h0000;
    endcase
  end

  assign m_stb_o = m_cyc_o;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= IDLE;
      row         <= 12'd0;
      step        <= 8'd0;
      tmo         <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      m_cyc_o     <= 1'b0;
      m_we_o      <= 1'b0;
      m_adr_o     <= 32'h0;
      m_dat_o     <= 32'h0;
      spike_valid <= 1'b0;
      spike_data  <= 32'h0;
      spike_step  <= 8'd0;
    end else begin
      done        <= 1'b0;
      spike_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error   <= 1'b0;
            row     <= 12'd0;
            step    <= 8'd0;
            tmo     <= 8'd0;
            busy    <= 1'b1;
            m_cyc_o <= 1'b1;
            m_we_o  <= 1'b0;
            m_dat_o <= 32'h0;
            m_adr_o <= {BASE_ADDR[31:16], 16'h0000};
            state   <= SYN_RD;
          end
        end
        SYN_RD, SPK_RD, DONE_WR: begin
          if (m_ack_i) begin
            m_cyc_o <= 1'b0;
            if (state == SYN_RD) begin
              state <= GAP;
              if (row == LAST_ROW) begin
                row  <= 12'd0;
                pend <= SPK_RD;
              end else begin
                row  <= row + 12'd1;
                pend <= SYN_RD;
              end
            end else if (state == SPK_RD) begin
              state       <= GAP;
              spike_data  <= m_dat_i;
              spike_step  <= step;
              spike_valid <= 1'b1;
              if (step == LAST_STEP) begin
                pend <= DONE_WR;
              end else begin
                step <= step + 8'd1;
                pend <= SYN_RD;
              end
            end else begin
              // The done write skips the gap and retires the picture immediately.
              m_we_o <= 1'b0;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end else if (tmo == TMO_LAST) begin
            m_cyc_o <= 1'b0;
            m_we_o  <= 1'b0;
            error   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        GAP: begin
          m_cyc_o <= 1'b1;
          tmo     <= 8'd0;
          m_adr_o <= {BASE_ADDR[31:16], nxt_off};
          m_we_o  <= (pend == DONE_WR);
          m_dat_o <= (pend == DONE_WR) ? 32'(NUM_STEPS) : 32'h0;
          state   <= pend;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_core_sequencer.sv
// tb/tb_nvm_core_sequencer.sv - directed self-checking bench for nvm_core_sequencer.
module tb_nvm_core_sequencer;

  logic wb_clk_i = 1'b0;
  logic rst_n = 1'b1;
  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: 2 rows, 1 step, timeout 4
  logic a_start = 1'b0;
  logic a_busy, a_done, a_error, a_cyc, a_stb, a_we, a_ack, a_sv;
  logic [31:0] a_adr, a_dat, a_dat_i, a_sdata;
  logic [7:0]  a_sstep;
  logic a_ack_en = 1'b1;
  int   a_wcnt = 0;

  nvm_core_sequencer #(.NUM_ROWS(2), .NUM_STEPS(1), .ACK_TIMEOUT(4)) dut_a (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .error(a_error), .m_cyc_o(a_cyc), .m_stb_o(a_stb), .m_we_o(a_we), .m_adr_o(a_adr),
    .m_dat_o(a_dat), .m_ack_i(a_ack), .m_dat_i(a_dat_i), .spike_valid(a_sv),
    .spike_data(a_sdata), .spike_step(a_sstep));

  always @(posedge wb_clk_i) a_wcnt <= (a_stb && !a_ack) ? a_wcnt + 1 : 0;
  assign a_ack   = a_ack_en && a_stb && (a_wcnt == 0);
  assign a_dat_i = {16'hBEEF, a_adr[15:0]};

  logic [31:0] a_adr_q[$];
  logic [31:0] a_dat_q[$];
  logic        a_we_q[$];
  int a_done_n = 0, a_spk_n = 0;
  logic [31:0] a_spk_data = 32'h0;
  logic [7:0]  a_spk_step = 8'hFF;
  always @(negedge wb_clk_i) begin
    if (a_cyc && a_ack) begin
      a_adr_q.push_back(a_adr);
      a_dat_q.push_back(a_dat);
      a_we_q.push_back(a_we);
    end
    if (a_done) a_done_n++;
    if (a_sv) begin
      a_spk_n++;
      a_spk_data = a_sdata;
      a_spk_step = a_sstep;
    end
  end

  // ---------------- instance B: defaults, 3-cycle ack delay
  logic b_start = 1'b0;
  logic b_busy, b_done, b_error, b_cyc, b_stb, b_we, b_ack, b_sv;
  logic [31:0] b_adr, b_dat, b_sdata;
  logic [7:0]  b_sstep;
  int b_wcnt = 0;

  nvm_core_sequencer dut_b (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .error(b_error), .m_cyc_o(b_cyc), .m_stb_o(b_stb), .m_we_o(b_we), .m_adr_o(b_adr),
    .m_dat_o(b_dat), .m_ack_i(b_ack), .m_dat_i(32'h0), .spike_valid(b_sv),
    .spike_data(b_sdata), .spike_step(b_sstep));

  always @(posedge wb_clk_i) b_wcnt <= (b_stb && !b_ack) ? b_wcnt + 1 : 0;
  assign b_ack = b_stb && (b_wcnt == 3);

  int b_txn = 0, b_spk_n = 0, b_step_err = 0, b_done_n = 0, b_unstable = 0;
  logic b_hold = 1'b0, b_pwe = 1'b0;
  logic [31:0] b_padr = 32'h0;
  always @(negedge wb_clk_i) begin
    if (b_cyc && b_ack) b_txn++;
    if (b_done) b_done_n++;
    if (b_sv) begin
      if (b_sstep != 8'(b_spk_n)) b_step_err++;
      b_spk_n++;
    end
    if (b_cyc && b_hold && (b_adr !== b_padr || b_we !== b_pwe)) b_unstable++;
    b_hold = b_cyc && !b_ack;
    b_padr = b_adr;
    b_pwe  = b_we;
  end

  // ---------------- instance C: 1024 rows, 1 step
  logic c_start = 1'b0;
  logic c_busy, c_done, c_error, c_cyc, c_stb, c_we, c_ack, c_sv;
  logic [31:0] c_adr, c_dat, c_sdata;
  logic [7:0]  c_sstep;

  nvm_core_sequencer #(.NUM_ROWS(1024), .NUM_STEPS(1)) dut_c (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n), .start(c_start), .busy(c_busy), .done(c_done),
    .error(c_error), .m_cyc_o(c_cyc), .m_stb_o(c_stb), .m_we_o(c_we), .m_adr_o(c_adr),
    .m_dat_o(c_dat), .m_ack_i(c_ack), .m_dat_i(32'h0), .spike_valid(c_sv),
    .spike_data(c_sdata), .spike_step(c_sstep));

  assign c_ack = c_stb;

  int c_txn = 0, c_syn_n = 0;
  logic [31:0] c_last_syn = 32'h0;
  always @(negedge wb_clk_i) begin
    if (c_cyc && c_ack) begin
      c_txn++;
      if (c_adr < 32'h3000_1000) begin
        c_syn_n++;
        c_last_syn = c_adr;
      end
    end
  end

  // ---------------- helpers (called at a negedge)
  task automatic pulse_a();
    a_start = 1'b1;
    @(negedge wb_clk_i);
    a_start = 1'b0;
  endtask

  task automatic wait_a_done(input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      if (a_done) begin
        n = i;
        break;
      end
      @(negedge wb_clk_i);
    end
  endtask

  task automatic check_a_seq(input string tag, input int base);
    check({tag, "_cnt"}, a_adr_q.size() - base, 4);
    if (a_adr_q.size() >= base + 4) begin
      check({tag, "_adr0"}, a_adr_q[base],     32'h3000_0000);
      check({tag, "_adr1"}, a_adr_q[base + 1], 32'h3000_0004);
      check({tag, "_adr2"}, a_adr_q[base + 2], 32'h3000_1000);
      check({tag, "_adr3"}, a_adr_q[base + 3], 32'h3000_2000);
      check({tag, "_we"},   {a_we_q[base], a_we_q[base + 1], a_we_q[base + 2], a_we_q[base + 3]}, 4'b0001);
      check({tag, "_wdat"}, a_dat_q[base + 3], 32'h1);
    end
  endtask

  int n, base, dn, sn, stb_n;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("rst_ctrl", {a_busy, a_done, a_error, a_cyc, a_stb, a_we, a_sv}, 7'b0);
    check("rst_adr", a_adr, 32'h0);
    check("rst_dat", a_dat, 32'h0);
    check("rst_spk", {a_sdata[23:0], a_sstep}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    check("idle_after_rst", {a_busy, a_cyc}, 2'b00);

    // zero-wait picture
    base = a_adr_q.size();
    pulse_a();
    check("t1_busy_e0", {a_busy, a_stb, a_cyc}, 3'b111);
    check("t1_adr_e0", a_adr, 32'h3000_0000);
    wait_a_done(40, n);
    check("t1_done_edge", n, 7);
    check("t1_busy_at_done", a_busy, 1'b0);
    @(negedge wb_clk_i);
    check("t1_done_pulse", a_done, 1'b0);
    check_a_seq("t1", base);
    check("t1_spk_n", a_spk_n, 1);
    check("t1_spk_data", a_spk_data, 32'hBEEF_1000);
    check("t1_spk_step", a_spk_step, 8'd0);
    check("t1_error", a_error, 1'b0);

    // start pulses while busy are ignored
    base = a_adr_q.size();
    dn = a_done_n;
    pulse_a();
    @(negedge wb_clk_i);
    pulse_a();
    @(negedge wb_clk_i);
    pulse_a();
    wait_a_done(40, n);
    check("t2_done_seen", n >= 0, 1'b1);
    repeat (6) @(negedge wb_clk_i);
    check_a_seq("t2", base);
    check("t2_done_n", a_done_n - dn, 1);
    check("t2_busy", a_busy, 1'b0);

    // ack timeout
    a_ack_en = 1'b0;
    dn = a_done_n;
    pulse_a();
    stb_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!a_busy) break;
      if (a_stb) stb_n++;
      @(negedge wb_clk_i);
    end
    check("t3_stb_cycles", stb_n, 4);
    check("t3_err_state", {a_error, a_busy, a_cyc, a_stb}, 4'b1000);
    repeat (4) @(negedge wb_clk_i);
    check("t3_no_done", a_done_n - dn, 0);
    check("t3_err_sticky", a_error, 1'b1);
    a_ack_en = 1'b1;
    base = a_adr_q.size();
    pulse_a();
    check("t3_err_cleared", a_error, 1'b0);
    check("t3_restart_adr", a_adr, 32'h3000_0000);
    wait_a_done(40, n);
    check("t3_restart_done", n, 7);
    @(negedge wb_clk_i);
    check_a_seq("t3", base);

    // reset in the middle of the spike read
    dn = a_done_n;
    sn = a_spk_n;
    pulse_a();
    for (int i = 0; i < 20; i++) begin
      if (a_cyc && a_adr == 32'h3000_1000) break;
      @(negedge wb_clk_i);
    end
    check("t4_in_spk", {a_cyc, a_adr}, {1'b1, 32'h3000_1000});
    rst_n = 1'b0;
    #1;
    check("t4_rst_ctrl", {a_busy, a_done, a_error, a_cyc, a_stb, a_we, a_sv}, 7'b0);
    check("t4_rst_adr", a_adr, 32'h0);
    check("t4_rst_spk", a_sdata, 32'h0);
    @(negedge wb_clk_i);
    rst_n = 1'b1;
    repeat (6) @(negedge wb_clk_i);
    check("t4_stays_idle", {a_busy, a_cyc}, 2'b00);
    check("t4_no_done", a_done_n - dn, 0);
    check("t4_no_spike", a_spk_n - sn, 0);

    // defaults, 3-cycle ack delay
    b_start = 1'b1;
    @(negedge wb_clk_i);
    b_start = 1'b0;
    n = -1;
    for (int i = 0; i < 2000; i++) begin
      if (b_done) begin
        n = i;
        break;
      end
      @(negedge wb_clk_i);
    end
    check("t5_done_edge", n, 684);
    repeat (4) @(negedge wb_clk_i);
    check("t5_txn", b_txn, 137);
    check("t5_spk_n", b_spk_n, 8);
    check("t5_step_order", b_step_err, 0);
    check("t5_done_n", b_done_n, 1);
    check("t5_stable", b_unstable, 0);
    check("t5_idle", {b_busy, b_error}, 2'b00);

    // 1024 rows: last synapse address and no spill into bit 12
    c_start = 1'b1;
    @(negedge wb_clk_i);
    c_start = 1'b0;
    n = -1;
    for (int i = 0; i < 5000; i++) begin
      if (c_done) begin
        n = i;
        break;
      end
      @(negedge wb_clk_i);
    end
    check("t6_done_edge", n, 2 * 1026 - 1);
    check("t6_txn", c_txn, 1026);
    check("t6_syn_n", c_syn_n, 1024);
    check("t6_last_syn", c_last_syn, 32'h3000_0FFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nvm_core_sequencer.md
# nvm_core_sequencer

Wishbone master that drives one inference picture through the NVM core's decoded address space. It issues synapse-row reads in region 0, a neuron-spike-out read in region 1 per timestep, and a final picture-done write in region 2. Each timestep's spike word is presented to downstream logic. The block sits between the SNN top-level control and the NVM core bus, replacing host-driven sequencing of the core.

## Interface
- NUM_ROWS, 16: synapse rows read per timestep (1..4096/4).
- NUM_STEPS, 8: timesteps per picture (1..255).
- BASE_ADDR, 32'h3000_0000: core base; bits [31:16] are used, bits [15:0] must be zero.
- ACK_TIMEOUT, 255: maximum cycles stb may wait for ack (1..255).
- wb_clk_i  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to sequence one picture; ignored while busy.
- busy  out  1  high while a picture is in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky ack-timeout flag, cleared by the next accepted start.
- m_cyc_o  out  1  bus cycle.
- m_stb_o  out  1  bus strobe; always equal to m_cyc_o.
- m_we_o  out  1  write enable.
- m_adr_o  out  32  byte address.
- m_dat_o  out  32  write data.
- m_ack_i  in  1  slave acknowledge.
- m_dat_i  in  32  read data.
- spike_valid  out  1  one-cycle pulse carrying spike_data.
- spike_data  out  32  captured spike-out word.
- spike_step  out  8  timestep index of spike_data.

## Operation
- States: IDLE, SYN_RD, SPK_RD, DONE_WR, GAP.
- IDLE: when start=1, clear error, zero the row counter r and step counter s, set busy, and go to SYN_RD.
- SYN_RD:
  - Drive adr = BASE_ADDR | 16'h0000 | r*4, we=0.
  - On ack, go to GAP. Read data is discarded.
  - Next state is SYN_RD with r+1, or SPK_RD when r = NUM_ROWS-1, in which case r wraps to 0.
- SPK_RD:
  - Drive adr = BASE_ADDR | 16'h1000, we=0.
  - On ack, capture m_dat_i into spike_data, set spike_step=s, and pulse spike_valid the next cycle.
  - Next state is SYN_RD with s+1, or DONE_WR when s = NUM_STEPS-1.
- DONE_WR: drive adr = BASE_ADDR | 16'h2000, we=1, dat = NUM_STEPS zero-extended. The ack ends the picture.
- GAP: one cycle with cyc=stb=0, then the pending next state. After the DONE_WR ack, the block pulses done, drops busy and returns to IDLE instead.
- Counters: r is 12 bits and s is 8 bits. Address offsets are formed by concatenation, with no carry into bits [15:12].
- Timeout:
  - An 8-bit counter runs while stb=1 and clears on entry to each transaction.
  - If it reaches ACK_TIMEOUT without ack, the block drops cyc/stb the next cycle, sets error, drops busy, returns to IDLE, and does not pulse done.
  - A late ack arriving in IDLE is ignored.
- A start pulse while busy=1 is ignored, with no queuing.
- Reset is asynchronous. Reset values:
  - busy, done, error, m_cyc_o, m_stb_o, m_we_o, spike_valid: 0.
  - m_adr_o, m_dat_o, spike_data, spike_step: 0.
  - State: IDLE.
- Reset mid-transaction aborts immediately. No completion is owed.

## Timing
- All outputs are registered.
- E0 is the edge that samples start=1. busy and the first stb are high after E0.
- Transaction k with zero wait:
  - stb is high after edge E(2k).
  - ack is sampled at E(2k+1).
  - The GAP cycle follows.
- Wait states extend the stb phase one cycle per missing ack. Outputs are held stable throughout.
- spike_valid is high for the single cycle after the SPK_RD ack edge.
- Total transactions = NUM_STEPS*(NUM_ROWS+1)+1. With zero-wait acks, done is high for the cycle after the last ack edge E(2T-1), where T is the total transaction count.
- busy falls on the same edge that done rises.
- A timeout with ack held low: stb stays high for ACK_TIMEOUT cycles, then cyc/stb/busy are 0 and error is 1 on the following edge.

## Test plan
- Zero-wait ack, NUM_ROWS=2, NUM_STEPS=1:
  - Bus addresses are 0x3000_0000, 0x3000_0004, 0x3000_1000, then a write of data 1 to 0x3000_2000.
  - done is high after E7.
  - spike_valid is high once with spike_data equal to the slave's returned word and spike_step=0.
- Defaults with a 3-cycle ack delay on every transaction: 137 transactions, 8 spike_valid pulses with steps 0..7, a single done pulse, and stable adr/we during each wait.
- ACK_TIMEOUT=4 with ack never asserted:
  - stb is high 4 cycles, then error=1, busy=0 and done never pulses.
  - The next start clears error and restarts at row 0.
- start pulses during busy: no effect on the address sequence or the transaction count.
- Reset asserted mid-SPK_RD: all outputs zero asynchronously. After release, the block stays in IDLE until start.
- NUM_ROWS=1024: the last synapse address is 0x3000_0FFC. The row counter wraps without touching bit 12.
